// File: rtl/instruction_fetch_controller_pkg.sv
// Shared types for the instruction fetch controller.
//   fetch_state_t : controller mode (normal fetch, loader owns port, post-load cleanup)
//   fetch_entry_t : one buffered fetch result {byte pc, instruction word}
//   QUEUE_DEPTH   : fetch buffer depth toward decode
package instruction_fetch_controller_pkg;

  typedef enum logic [1:0] {RUN = 2'd0, LOAD = 2'd1, FLUSH = 2'd2} fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int QUEUE_DEPTH = 2;

  // Fetch addresses are word aligned; the low two bits of any target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_controller_if.sv
// Bus bundle around the fetch controller.
//   memory port : mem_en, mem_we, mem_addr, mem_wdata (to memory), mem_rdata (from memory)
//   decode side : if_valid, if_instr, if_pc (to decode), if_ready (from decode)
//   redirect    : redirect_valid, redirect_pc (from execute)
//   loader      : ld_req, ld_we, ld_addr, ld_wdata (from loader), ld_gnt (to loader)
// master = the controller, slave = everything around it.
interface instruction_fetch_controller_if #(parameter int AW = 6);
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          if_valid;
  logic          if_ready;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_gnt;

  modport master (
    output mem_en, mem_we, mem_addr, mem_wdata, if_valid, if_instr, if_pc, ld_gnt,
    input  mem_rdata, if_ready, redirect_valid, redirect_pc, ld_req, ld_we, ld_addr, ld_wdata
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, mem_wdata, if_valid, if_instr, if_pc, ld_gnt,
    output mem_rdata, if_ready, redirect_valid, redirect_pc, ld_req, ld_we, ld_addr, ld_wdata
  );
endinterface

// File: rtl/instruction_fetch_controller_fetch_queue.sv
// Two-entry FIFO of fetch results. Head is taken straight from storage so the
// decode-facing outputs are registered.
//   clk, reset      : clock, synchronous active-high reset
//   push, din       : enqueue din
//   pop             : dequeue head (ignored when empty)
//   flush           : drop all entries (wins over push/pop)
//   head_valid/head : oldest entry
//   occ             : current occupancy 0..2
module instruction_fetch_controller_fetch_queue
  import instruction_fetch_controller_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         head_valid,
  output fetch_entry_t head,
  output logic [1:0]   occ
);
  fetch_entry_t ent [QUEUE_DEPTH];
  logic [1:0]   cnt;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop && (cnt != 2'd0);
  // A full queue only accepts when the head leaves in the same cycle.
  assign push_ok = push && ((cnt != 2'd2) || pop_ok);

  always_ff @(posedge clk) begin
    if (reset || flush) cnt <= 2'd0;
    else                cnt <= cnt + {1'b0, push_ok} - {1'b0, pop_ok};
    if (pop_ok) ent[0] <= ent[1];
    // Landing slot is the post-pop occupancy; a later NBA to ent[0] overrides the shift.
    if (push_ok) begin
      if (cnt == {1'b0, pop_ok}) ent[0] <= din;
      else                       ent[1] <= din;
    end
  end

  assign head_valid = (cnt != 2'd0);
  assign head       = ent[0];
  assign occ        = cnt;
endmodule

// File: rtl/instruction_fetch_controller.sv
// Fetch sequencer for a 1-cycle-latency single-port instruction memory.
// Owns the fetch PC, issues at most one read per cycle while buffer credit
// allows, buffers responses in a 2-entry queue toward decode, handles
// redirects with an epoch tag, and hands the port to the boot loader.
//   clk, reset : clock, synchronous active-high reset
//   bus        : master side of instruction_fetch_controller_if
module instruction_fetch_controller
  import instruction_fetch_controller_pkg::*;
#(
  parameter int          NUM_INSTR = 64,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic clk,
  input logic reset,
  instruction_fetch_controller_if.master bus
);
  localparam int AW = $clog2(NUM_INSTR);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q;
  logic         epoch_q;
  logic         infl_q;
  logic [31:0]  infl_pc_q;
  logic         infl_epoch_q;

  logic         run, pop, push, qflush, issue, redir;
  logic         q_valid;
  fetch_entry_t q_head;
  logic [1:0]   q_occ;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (bus.ld_req) state_d = LOAD;
      LOAD:    if (!bus.ld_req) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign run   = (state_q == RUN);
  assign pop   = run && q_valid && bus.if_ready;
  // Loader takeover outranks redirect, which outranks issue.
  assign redir = run && !bus.ld_req && bus.redirect_valid;
  // Credit: queue slots not already claimed by buffered or in-flight words,
  // plus the slot freed by this cycle's transfer.
  assign issue = run && !bus.ld_req && !bus.redirect_valid &&
                 (({1'b0, q_occ} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop}));
  assign push   = run && infl_q && (infl_epoch_q == epoch_q);
  assign qflush = !run || redir;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      epoch_q      <= 1'b0;
      infl_q       <= 1'b0;
      infl_pc_q    <= 32'h0;
      infl_epoch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      infl_q  <= issue;
      if (issue) begin
        infl_pc_q    <= pc_q;
        infl_epoch_q <= epoch_q;
        pc_q         <= pc_q + 32'd4;
      end
      if (redir) begin
        epoch_q <= ~epoch_q;
        pc_q    <= align_pc(bus.redirect_pc);
      end
      if (state_q == FLUSH) pc_q <= RESET_PC;
    end
  end

  instruction_fetch_controller_fetch_queue u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (qflush),
    .din        ('{pc: infl_pc_q, instr: bus.mem_rdata}),
    .head_valid (q_valid),
    .head       (q_head),
    .occ        (q_occ)
  );

  // Port mux; everything held at 0 while reset is asserted.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'h0;
    if (!reset) begin
      if (state_q == LOAD) begin
        bus.mem_en    = bus.ld_we;
        bus.mem_we    = bus.ld_we;
        bus.mem_addr  = bus.ld_addr;
        bus.mem_wdata = bus.ld_wdata;
      end else if (issue) begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = pc_q[AW+1:2];
      end
    end
  end

  assign bus.if_valid = !reset && run && q_valid;
  assign bus.if_pc    = bus.if_valid ? q_head.pc : 32'h0;
  assign bus.if_instr = bus.if_valid ? q_head.instr : 32'h0;
  assign bus.ld_gnt   = !reset && (state_q == LOAD);
endmodule

// File: tb/tb_instruction_fetch_controller.sv
module tb_instruction_fetch_controller;
  import instruction_fetch_controller_pkg::*;

  localparam int          NUM_INSTR = 64;
  localparam int          AW        = 6;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_fetch_controller_if #(.AW(AW)) bus ();

  instruction_fetch_controller #(.NUM_INSTR(NUM_INSTR), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference memory contents (initial image plus every granted loader write).
  logic [31:0] ref_mem [NUM_INSTR];

  // Memory the DUT talks to: 1-cycle read latency, word indexed.
  logic [31:0] env_mem [NUM_INSTR];
  logic        env_init;
  logic [31:0] rdata_q;
  always @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < NUM_INSTR; i++) env_mem[i] <= ref_mem[i];
    end else if (bus.mem_en) begin
      if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wdata;
      else            rdata_q <= env_mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rdata_q;

  // Behavioural model: mode flags, fetch pointer, outstanding read, decode queue.
  bit           m_loading, m_flush, m_infl;
  logic [31:0]  m_pc, m_infl_pc;
  fetch_entry_t m_q[$];

  function automatic int widx(input logic [31:0] byte_addr);
    return int'((byte_addr >> 2) % NUM_INSTR);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit          e_en, e_we, e_valid, e_gnt, pop;
    logic [31:0] e_addr, e_wdata;
    e_en = 0; e_we = 0; e_valid = 0; e_gnt = 0; e_addr = 0; e_wdata = 0;
    if (!reset) begin
      if (m_loading) begin
        e_gnt = 1; e_en = bus.ld_we; e_we = bus.ld_we;
        e_addr = 32'(bus.ld_addr); e_wdata = bus.ld_wdata;
      end else if (!m_flush) begin
        e_valid = (m_q.size() != 0);
        pop = e_valid && bus.if_ready;
        if (!bus.ld_req && !bus.redirect_valid &&
            (m_q.size() + int'(m_infl) < 2 + int'(pop))) begin
          e_en = 1; e_addr = 32'(widx(m_pc));
        end
      end
    end
    chk("mem_en", 32'(bus.mem_en), 32'(e_en));
    chk("mem_we", 32'(bus.mem_we), 32'(e_we));
    if (e_en) chk("mem_addr", 32'(bus.mem_addr), e_addr);
    if (e_we) chk("mem_wdata", bus.mem_wdata, e_wdata);
    chk("ld_gnt", 32'(bus.ld_gnt), 32'(e_gnt));
    chk("if_valid", 32'(bus.if_valid), 32'(e_valid));
    if (e_valid) begin
      chk("if_pc", bus.if_pc, m_q[0].pc);
      chk("if_instr", bus.if_instr, m_q[0].instr);
    end
    chk("queue_no_overflow", 32'(dut.u_queue.occ <= 2'd2), 32'd1);
  endtask

  task automatic model_step();
    bit pop, iss;
    if (reset) begin
      m_loading = 0; m_flush = 0; m_infl = 0; m_pc = RESET_PC; m_q.delete();
      return;
    end
    if (m_loading) begin
      if (bus.ld_we) ref_mem[bus.ld_addr] = bus.ld_wdata;
      if (!bus.ld_req) begin m_loading = 0; m_flush = 1; end
    end else if (m_flush) begin
      m_flush = 0; m_infl = 0; m_pc = RESET_PC; m_q.delete();
    end else begin
      pop = (m_q.size() != 0) && bus.if_ready;
      if (bus.ld_req) begin
        m_loading = 1; m_infl = 0; m_q.delete();
      end else if (bus.redirect_valid) begin
        m_infl = 0; m_q.delete(); m_pc = bus.redirect_pc & ~32'h3;
      end else begin
        iss = (m_q.size() + int'(m_infl) < 2 + int'(pop));
        if (pop) void'(m_q.pop_front());
        if (m_infl) m_q.push_back('{pc: m_infl_pc, instr: ref_mem[widx(m_infl_pc)]});
        m_infl = iss;
        if (iss) begin m_infl_pc = m_pc; m_pc = m_pc + 32'd4; end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    bit seen;
    int ld_left;
    reset = 1; env_init = 1;
    bus.if_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    bus.ld_req = 0; bus.ld_we = 0; bus.ld_addr = '0; bus.ld_wdata = 0;
    for (int i = 0; i < NUM_INSTR; i++) ref_mem[i] = $urandom;
    m_pc = RESET_PC; m_infl_pc = 0;
    tick(); tick();
    env_init = 0; reset = 0;

    // Streaming from RESET_PC
    bus.if_ready = 1;
    repeat (12) tick();

    // Backpressure: queue fills to two and issue stops
    bus.if_ready = 0;
    repeat (5) tick();
    chk("backpressure_occ", 32'(dut.u_queue.occ), 32'd2);
    bus.if_ready = 1;
    repeat (6) tick();

    // Redirect while a read is in flight; low bits dropped
    bus.redirect_valid = 1; bus.redirect_pc = 32'h22;
    tick();
    bus.redirect_valid = 0;
    repeat (6) tick();

    // Word-index wrap
    bus.redirect_valid = 1; bus.redirect_pc = 32'hFC;
    tick();
    bus.redirect_valid = 0;
    repeat (6) tick();

    // Load session writing word 3, then restart at RESET_PC
    bus.ld_req = 1;
    tick(); tick();
    bus.ld_we = 1; bus.ld_addr = AW'(3); bus.ld_wdata = 32'hDEADBEEF;
    tick();
    bus.ld_we = 0;
    tick();
    bus.ld_req = 0;
    tick(); tick();
    seen = 0;
    repeat (8) begin
      tick();
      if (bus.if_valid && bus.if_pc == 32'hC) begin
        chk("load_word3", bus.if_instr, 32'hDEADBEEF);
        seen = 1;
      end
    end
    chk("load_word3_fetched", 32'(seen), 32'd1);

    // Reset in the middle of a load write
    bus.ld_req = 1;
    tick(); tick();
    bus.ld_we = 1; bus.ld_addr = AW'(5); bus.ld_wdata = $urandom;
    reset = 1;
    tick();
    reset = 0; bus.ld_req = 0; bus.ld_we = 0;
    repeat (6) tick();

    // Randomised traffic: backpressure, redirects, short load sessions
    ld_left = 0;
    repeat (600) begin
      bus.if_ready = 1'($urandom_range(0, 3) != 0);
      if (ld_left > 0) begin
        bus.ld_req = 1; ld_left--;
        bus.ld_we = 1'($urandom_range(0, 1));
        bus.ld_addr = AW'($urandom_range(0, NUM_INSTR - 1));
        bus.ld_wdata = $urandom;
      end else begin
        bus.ld_req = 0; bus.ld_we = 0;
        if ($urandom_range(0, 49) == 0) ld_left = $urandom_range(2, 6);
      end
      bus.redirect_valid = ($urandom_range(0, 11) == 0);
      bus.redirect_pc = $urandom;
      tick();
    end
    bus.redirect_valid = 0; bus.ld_req = 0; bus.ld_we = 0; bus.if_ready = 1;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
